ifu_mc: RTL and testbench

//  Multicycle instruction fetch unit; sits directly upstream of ctrl. Holds PC and IR, computes NPC from

---
 rtl/ifu_mc.sv | 139 +++++++++++++
 tb/tb_ifu_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_mc.sv
// Multicycle instruction fetch unit: PC/IR, next-PC selection and a one-word
// prefetch buffer filled from a variable-latency instruction memory.
module ifu_mc #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWr,
    input  logic        IRWr,
    input  logic [1:0]  NPCOp,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IR,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic        fetch_stall,
    output logic        fetch_err
);

    localparam int unsigned CW = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    // IDLE: buffer holds mem[PC]; REQ: fetching mem[PC]; DROP: stale fetch in flight
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   npc;
    logic [31:0]   pf_word;
    logic [31:0]   drop_addr;
    logic [CW-1:0] tcnt, tcnt_nx;
    logic          pc_ld, ir_ld, pf_ld, drop_ld, err_set;
    logic          in_req;

    assign in_req      = (state != S_IDLE);
    assign imem_req    = in_req;
    assign imem_addr   = (state == S_DROP) ? drop_addr : PC;
    assign fetch_stall = IRWr && (state != S_IDLE);
    assign Op          = IR[31:26];
    assign Funct       = IR[5:0];

    // Next-PC selection; reserved encoding behaves as PLUS4
    always_comb begin
        npc = PC + 32'd4;
        case (NPCOp)
            NPC_PLUS4:  npc = PC + 32'd4;
            NPC_BRANCH: npc = PC + {{14{IR[15]}}, IR[15:0], 2'b00};
            NPC_JUMP:   npc = {PC[31:28], IR[25:0], 2'b00};
            default:    npc = PC + 32'd4;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_REQ;
        else     state <= state_nx;
    end

    // Next-state and register load enables; a stalled IRWr suppresses PCWr
    always_comb begin
        state_nx = state;
        pc_ld    = 1'b0;
        ir_ld    = 1'b0;
        pf_ld    = 1'b0;
        drop_ld  = 1'b0;
        case (state)
            S_IDLE: begin
                if (IRWr) ir_ld = 1'b1;
                if (PCWr) begin
                    pc_ld    = 1'b1;
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (IRWr) begin
                    if (imem_ack) begin
                        pf_ld    = 1'b1;
                        state_nx = S_IDLE;
                    end
                end else if (PCWr) begin
                    pc_ld = 1'b1;
                    if (!imem_ack) begin
                        drop_ld  = 1'b1;
                        state_nx = S_DROP;
                    end
                end else if (imem_ack) begin
                    pf_ld    = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DROP: begin
                if (PCWr && !IRWr) pc_ld = 1'b1;
                if (imem_ack) state_nx = S_REQ;
            end
            default: state_nx = S_REQ;
        endcase
    end

    // Request-age counter, saturating at the timeout
    always_comb begin
        tcnt_nx = tcnt;
        err_set = 1'b0;
        if (!in_req || imem_ack) begin
            tcnt_nx = '0;
        end else if (tcnt != CW'(IMEM_TIMEOUT)) begin
            tcnt_nx = tcnt + CW'(1);
            if (tcnt_nx == CW'(IMEM_TIMEOUT)) err_set = 1'b1;
        end
    end

    // Architectural and buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            PC        <= RESET_PC;
            IR        <= '0;
            pf_word   <= '0;
            drop_addr <= '0;
            tcnt      <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (pc_ld)   PC        <= npc;
            if (ir_ld)   IR        <= pf_word;
            if (pf_ld)   pf_word   <= imem_rdata;
            if (drop_ld) drop_addr <= PC;
            tcnt <= tcnt_nx;
            if (err_set) fetch_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_mc.sv
// Directed bench for ifu_mc: fetch, stall, branch, drop, timeout and PC wrap.
module tb_ifu_mc;

    logic        clk;
    logic        rst;
    logic        PCWr;
    logic        IRWr;
    logic [1:0]  NPCOp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] IR;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        fetch_stall;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    ifu_mc dut (
        .clk(clk), .rst(rst), .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .PC(PC), .IR(IR), .Op(Op), .Funct(Funct),
        .fetch_stall(fetch_stall), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PCWr = 1'b0; IRWr = 1'b0; NPCOp = 2'b00;
        imem_ack = 1'b0; imem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        total++; if (PC !== 32'h0000_3000) begin bad++; $display("FAIL rst_pc got=%h exp=%h", PC, 32'h0000_3000); end
        total++; if (IR !== 32'h0) begin bad++; $display("FAIL rst_ir got=%h exp=%h", IR, 32'h0); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0000_3000) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0000_3000); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", fetch_stall); end
    endtask

    task automatic test_fetch();
        imem_ack = 1'b1; imem_rdata = 32'h3408_0005;
        tick();
        imem_ack = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL f_idle_req got=%b exp=0", imem_req); end
        IRWr = 1'b1; PCWr = 1'b1; NPCOp = 2'b00;
        #1;
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL f_nostall got=%b exp=0", fetch_stall); end
        tick();
        IRWr = 1'b0; PCWr = 1'b0;
        total++; if (IR !== 32'h3408_0005) begin bad++; $display("FAIL f_ir got=%h exp=%h", IR, 32'h3408_0005); end
        total++; if (Op !== 6'h0D) begin bad++; $display("FAIL f_op got=%h exp=%h", Op, 6'h0D); end
        total++; if (Funct !== 6'h05) begin bad++; $display("FAIL f_funct got=%h exp=%h", Funct, 6'h05); end
        total++; if (PC !== 32'h0000_3004) begin bad++; $display("FAIL f_pc got=%h exp=%h", PC, 32'h0000_3004); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL f_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0000_3004) begin bad++; $display("FAIL f_addr got=%h exp=%h", imem_addr, 32'h0000_3004); end
    endtask

    task automatic test_stall();
        IRWr = 1'b1; PCWr = 1'b1; NPCOp = 2'b00;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL s_stall%0d got=%b exp=1", i, fetch_stall); end
            total++; if (PC !== 32'h0000_3004) begin bad++; $display("FAIL s_pc%0d got=%h exp=%h", i, PC, 32'h0000_3004); end
            total++; if (IR !== 32'h3408_0005) begin bad++; $display("FAIL s_ir%0d got=%h exp=%h", i, IR, 32'h3408_0005); end
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
        tick();
        imem_ack = 1'b0;
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL s_release got=%b exp=0", fetch_stall); end
        total++; if (IR !== 32'h3408_0005) begin bad++; $display("FAIL s_ir_hold got=%h exp=%h", IR, 32'h3408_0005); end
        tick();
        IRWr = 1'b0; PCWr = 1'b0;
        total++; if (IR !== 32'h1000_FFFE) begin bad++; $display("FAIL s_ir_new got=%h exp=%h", IR, 32'h1000_FFFE); end
        total++; if (Op !== 6'h04) begin bad++; $display("FAIL s_op got=%h exp=%h", Op, 6'h04); end
        total++; if (PC !== 32'h0000_3008) begin bad++; $display("FAIL s_pc_new got=%h exp=%h", PC, 32'h0000_3008); end
    endtask

    task automatic test_branch();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL b_idle got=%b exp=0", imem_req); end
        PCWr = 1'b1; NPCOp = 2'b01;
        tick();
        PCWr = 1'b0;
        total++; if (PC !== 32'h0000_3000) begin bad++; $display("FAIL b_pc got=%h exp=%h", PC, 32'h0000_3000); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL b_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0000_3000) begin bad++; $display("FAIL b_addr got=%h exp=%h", imem_addr, 32'h0000_3000); end
        IRWr = 1'b1;
        #1;
        total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL b_discard got=%b exp=1", fetch_stall); end
        IRWr = 1'b0;
    endtask

    task automatic test_jump_drop();
        imem_ack = 1'b1; imem_rdata = 32'h0C00_0C01;
        tick();
        imem_ack = 1'b0; IRWr = 1'b1; PCWr = 1'b1; NPCOp = 2'b00;
        tick();
        IRWr = 1'b0; PCWr = 1'b0;
        total++; if (IR !== 32'h0C00_0C01) begin bad++; $display("FAIL j_ir got=%h exp=%h", IR, 32'h0C00_0C01); end
        total++; if (PC !== 32'h0000_3004) begin bad++; $display("FAIL j_pc got=%h exp=%h", PC, 32'h0000_3004); end
        PCWr = 1'b1; NPCOp = 2'b00;
        tick();
        PCWr = 1'b0;
        total++; if (PC !== 32'h0000_3008) begin bad++; $display("FAIL d_pc got=%h exp=%h", PC, 32'h0000_3008); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL d_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0000_3004) begin bad++; $display("FAIL d_old_addr got=%h exp=%h", imem_addr, 32'h0000_3004); end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        total++; if (imem_addr !== 32'h0000_3008) begin bad++; $display("FAIL d_new_addr got=%h exp=%h", imem_addr, 32'h0000_3008); end
        IRWr = 1'b1;
        #1;
        total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL d_discard got=%b exp=1", fetch_stall); end
        IRWr = 1'b0;
        PCWr = 1'b1; NPCOp = 2'b10;
        tick();
        PCWr = 1'b0;
        total++; if (PC !== 32'h0000_3004) begin bad++; $display("FAIL j_target got=%h exp=%h", PC, 32'h0000_3004); end
        total++; if (imem_addr !== 32'h0000_3008) begin bad++; $display("FAIL j_drop_addr got=%h exp=%h", imem_addr, 32'h0000_3008); end
        imem_ack = 1'b1; imem_rdata = 32'hBAD1_BAD1;
        tick();
        imem_ack = 1'b0;
        total++; if (imem_addr !== 32'h0000_3004) begin bad++; $display("FAIL j_req_addr got=%h exp=%h", imem_addr, 32'h0000_3004); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL j_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_timeout();
        repeat (15) tick();
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL t_early got=%b exp=0", fetch_err); end
        tick();
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL t_err got=%b exp=1", fetch_err); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL t_req got=%b exp=1", imem_req); end
        tick();
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL t_sticky got=%b exp=1", fetch_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL t_clr got=%b exp=0", fetch_err); end
        total++; if (PC !== 32'h0000_3000) begin bad++; $display("FAIL t_pc got=%h exp=%h", PC, 32'h0000_3000); end
        total++; if (imem_addr !== 32'h0000_3000) begin bad++; $display("FAIL t_addr got=%h exp=%h", imem_addr, 32'h0000_3000); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'h0800_0000;
        tick();
        imem_ack = 1'b0; IRWr = 1'b1; PCWr = 1'b1; NPCOp = 2'b11;
        tick();
        IRWr = 1'b0; PCWr = 1'b0;
        total++; if (PC !== 32'h0000_3004) begin bad++; $display("FAIL w_op11 got=%h exp=%h", PC, 32'h0000_3004); end
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; PCWr = 1'b1; NPCOp = 2'b10;
        tick();
        imem_ack = 1'b0; PCWr = 1'b0;
        total++; if (PC !== 32'h0000_0000) begin bad++; $display("FAIL w_jump0 got=%h exp=%h", PC, 32'h0);  end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL w_ackpc_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0000_0000) begin bad++; $display("FAIL w_ackpc_addr got=%h exp=%h", imem_addr, 32'h0); end
        imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
        tick();
        imem_ack = 1'b0; IRWr = 1'b1; PCWr = 1'b1; NPCOp = 2'b00;
        tick();
        IRWr = 1'b0; PCWr = 1'b0;
        total++; if (IR !== 32'h1000_FFFE) begin bad++; $display("FAIL w_ir got=%h exp=%h", IR, 32'h1000_FFFE); end
        PCWr = 1'b1; NPCOp = 2'b01;
        tick();
        PCWr = 1'b0;
        total++; if (PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL w_neg got=%h exp=%h", PC, 32'hFFFF_FFFC); end
        imem_ack = 1'b1; imem_rdata = 32'h0;
        tick();
        imem_ack = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL w_addr got=%h exp=%h", imem_addr, 32'hFFFF_FFFC); end
        PCWr = 1'b1; NPCOp = 2'b00;
        tick();
        PCWr = 1'b0;
        total++; if (PC !== 32'h0000_0000) begin bad++; $display("FAIL w_wrap got=%h exp=%h", PC, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_jump_drop();
        test_timeout();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
